fma_pipe: RTL and testbench

FMA_PIPE -- requirements
Module: fma_pipe

---
 rtl/fma_pipe_if.sv | 27 ++
 rtl/fma_pipe.sv | 89 ++++++++
 tb/tb_fma_pipe.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/fma_pipe_if.sv
// rtl/fma_pipe_if.sv - operand/result handshake bundle for fma_pipe
interface fma_pipe_if #(
    parameter int WIDTH = 16
);
    localparam int RW = 2 * WIDTH;

    logic                    in_valid;
    logic                    in_ready;
    logic signed [WIDTH-1:0] a;
    logic signed [WIDTH-1:0] b;
    logic signed [WIDTH-1:0] c;
    logic                    acc_mode;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [RW-1:0]    out;
    logic                    overflow;

    modport master (
        output in_valid, a, b, c, acc_mode, out_ready,
        input  in_ready, out_valid, out, overflow
    );

    modport slave (
        input  in_valid, a, b, c, acc_mode, out_ready,
        output in_ready, out_valid, out, overflow
    );
endinterface

// File: rtl/fma_pipe.sv
// rtl/fma_pipe.sv - 3-stage signed multiply-add/accumulate pipeline; FMA_PIPE_SAT_EN selects saturating add
module fma_pipe #(
    parameter int WIDTH = 16
) (
    input  logic      clk,
    input  logic      rst,
    fma_pipe_if.slave bus
);
    localparam int RW = 2 * WIDTH;

    logic                    advance;

    logic                    s1_valid;
    logic signed [WIDTH-1:0] s1_a;
    logic signed [WIDTH-1:0] s1_b;
    logic signed [WIDTH-1:0] s1_c;
    logic                    s1_mode;

    logic                    s2_valid;
    logic signed [RW-1:0]    s2_prod;
    logic signed [RW-1:0]    s2_c;
    logic                    s2_mode;

    logic                    s3_valid;
    logic signed [RW-1:0]    s3_sum;
    logic                    s3_ovf;
    logic signed [RW-1:0]    acc;

    logic signed [RW-1:0]    a_ext;
    logic signed [RW-1:0]    b_ext;
    logic signed [RW-1:0]    prod;
    logic signed [RW-1:0]    addend;
    logic signed [RW-1:0]    raw_sum;
    logic signed [RW-1:0]    sum;
    logic                    ovf;

    // Single global stall: the whole pipe moves only when S3 can be vacated.
    assign advance       = !s3_valid || bus.out_ready;
    assign bus.in_ready  = advance;
    assign bus.out_valid = s3_valid;
    assign bus.out       = s3_sum;
    assign bus.overflow  = s3_ovf;

    assign a_ext = {{WIDTH{s1_a[WIDTH-1]}}, s1_a};
    assign b_ext = {{WIDTH{s1_b[WIDTH-1]}}, s1_b};
    assign prod  = a_ext * b_ext;

    always_comb begin
        addend  = s2_mode ? acc : s2_c;
        raw_sum = s2_prod + addend;
        ovf     = (s2_prod[RW-1] == addend[RW-1]) && (raw_sum[RW-1] != s2_prod[RW-1]);
        sum     = raw_sum;
`ifdef FMA_PIPE_SAT_EN
        if (ovf) begin
            sum = s2_prod[RW-1] ? {1'b1, {(RW-1){1'b0}}} : {1'b0, {(RW-1){1'b1}}};
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s3_valid <= 1'b0;
            s3_sum   <= '0;
            s3_ovf   <= 1'b0;
            acc      <= '0;
        end else if (advance) begin
            s1_valid <= bus.in_valid;
            s1_a     <= bus.a;
            s1_b     <= bus.b;
            s1_c     <= bus.c;
            s1_mode  <= bus.acc_mode;

            s2_valid <= s1_valid;
            s2_prod  <= prod;
            s2_c     <= {{WIDTH{s1_c[WIDTH-1]}}, s1_c};
            s2_mode  <= s1_mode;

            // Bubbles leave the last result and the accumulator untouched.
            s3_valid <= s2_valid;
            if (s2_valid) begin
                s3_sum <= sum;
                s3_ovf <= ovf;
                acc    <= sum;
            end
        end
    end
endmodule

// File: tb/tb_fma_pipe.sv
// tb/tb_fma_pipe.sv - self-checking bench for fma_pipe: directed table, corner sequences, random vs reference model
module tb_fma_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    fma_pipe_if #(.WIDTH(16)) intf ();

    fma_pipe #(.WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (intf.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          a;
        int          b;
        int          c;
        bit          m;
        logic [31:0] r;
        bit          o;
    } vec_t;

    vec_t        tbl[6];
    logic [31:0] exp_r[$];
    bit          exp_o[$];
    logic [31:0] got_out[$];
    bit          got_ovf[$];
    int          got_cyc[$];
    int          macc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    // Reference: exact integer arithmetic, then wrap or clamp to 32 bits.
    task automatic model(input int a, input int b, input int c, input bit m);
        longint p, s;
        logic [31:0] r;
        bit o;
        p = longint'(a) * longint'(b);
        s = p + (m ? longint'(macc) : longint'(c));
        o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        r = s[31:0];
`ifdef FMA_PIPE_SAT_EN
        if (s > 64'sd2147483647) r = 32'h7FFF_FFFF;
        else if (s < -64'sd2147483648) r = 32'h8000_0000;
`endif
        macc = $signed(r);
        exp_r.push_back(r);
        exp_o.push_back(o);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            exp_r.delete();
            exp_o.delete();
            macc = 0;
        end else begin
            if (intf.out_valid && intf.out_ready) begin
                got_out.push_back(intf.out);
                got_ovf.push_back(intf.overflow);
                got_cyc.push_back(cyc);
                if (exp_r.size() == 0) begin
                    chk("unexpected_out", 32'd1, 32'd0);
                end else begin
                    chk("model_out", intf.out, exp_r.pop_front());
                    chk("model_ovf", {31'd0, intf.overflow}, {31'd0, exp_o.pop_front()});
                end
            end
            if (intf.in_valid && intf.in_ready)
                model(int'(intf.a), int'(intf.b), int'(intf.c), intf.acc_mode);
        end
    end

    task automatic set_in(input int a, input int b, input int c, input bit m);
        intf.a        = a[15:0];
        intf.b        = b[15:0];
        intf.c        = c[15:0];
        intf.acc_mode = m;
        intf.in_valid = 1'b1;
    endtask

    task automatic send(input int a, input int b, input int c, input bit m, input bit rnd);
        bit ok;
        ok = 1'b0;
        set_in(a, b, c, m);
        for (int i = 0; i < 200 && !ok; i++) begin
            if (rnd) intf.out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            ok = intf.in_ready;
            @(posedge clk);
            #1;
        end
        if (!ok) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        intf.in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic drain();
        intf.in_valid  = 1'b0;
        intf.out_ready = 1'b1;
        for (int i = 0; i < 100 && exp_r.size() != 0; i++) @(posedge clk);
        #1;
        chk("drain_left", exp_r.size(), 32'd0);
    endtask

    initial begin
        int nacc, base;
        intf.in_valid  = 1'b0;
        intf.out_ready = 1'b1;
        set_in(0, 0, 0, 1'b0);
        intf.in_valid  = 1'b0;

        tbl[0] = '{287, 257, 23, 1'b0, 32'd73782, 1'b0};
        tbl[1] = '{2, 3, 5, 1'b0, 32'd11, 1'b0};
        tbl[2] = '{4, 4, 99, 1'b1, 32'd27, 1'b0};
        tbl[3] = '{-3, 7, -10, 1'b0, 32'hFFFF_FFE1, 1'b0};
        tbl[4] = '{-32768, -32768, 0, 1'b0, 32'h4000_0000, 1'b0};
`ifdef FMA_PIPE_SAT_EN
        tbl[5] = '{-32768, -32768, 0, 1'b1, 32'h7FFF_FFFF, 1'b1};
`else
        tbl[5] = '{-32768, -32768, 0, 1'b1, 32'h8000_0000, 1'b1};
`endif

        repeat (2) @(posedge clk);
        #1;
        do_reset();
        chk("rst_out_valid", {31'd0, intf.out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, intf.in_ready}, 32'd1);
        chk("rst_out", intf.out, 32'd0);
        chk("rst_overflow", {31'd0, intf.overflow}, 32'd0);

        // Latency: presented in cycle 0, valid on out after the third edge.
        send(287, 257, 23, 1'b0, 1'b0);
        intf.in_valid = 1'b0;
        chk("lat_edge1", {31'd0, intf.out_valid}, 32'd0);
        @(posedge clk); #1;
        chk("lat_edge2", {31'd0, intf.out_valid}, 32'd0);
        @(posedge clk); #1;
        chk("lat_edge3_valid", {31'd0, intf.out_valid}, 32'd1);
        chk("lat_out", intf.out, 32'd73782);
        chk("lat_ovf", {31'd0, intf.overflow}, 32'd0);
        drain();

        got_out.delete(); got_ovf.delete(); got_cyc.delete();
        foreach (tbl[i]) send(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].m, 1'b0);
        drain();
        chk("tbl_count", got_out.size(), 32'd6);
        if (got_out.size() == 6) begin
            foreach (tbl[i]) begin
                chk($sformatf("tbl%0d_out", i), got_out[i], tbl[i].r);
                chk($sformatf("tbl%0d_ovf", i), {31'd0, got_ovf[i]}, {31'd0, tbl[i].o});
            end
            chk("chain_consecutive", got_cyc[2] - got_cyc[1], 32'd1);
        end

        // Backpressure: only three triples fit while out is blocked.
        base = got_out.size();
        intf.out_ready = 1'b0;
        nacc = 0;
        for (int k = 0; k < 6; k++) begin
            set_in(nacc + 1, nacc + 2, 10 * nacc, nacc[0]);
            @(negedge clk);
            if (intf.in_ready) nacc++;
            @(posedge clk); #1;
        end
        chk("bp_accepted", nacc, 32'd3);
        chk("bp_in_ready", {31'd0, intf.in_ready}, 32'd0);
        intf.out_ready = 1'b1;
        for (int k = nacc; k < 5; k++) send(k + 1, k + 2, 10 * k, k[0], 1'b0);
        drain();
        chk("bp_results", got_out.size() - base, 32'd5);

        // Reset with two triples in flight must also clear the accumulator.
        send(5, 5, 1, 1'b0, 1'b0);
        send(6, 6, 0, 1'b0, 1'b0);
        rst = 1'b1;
        intf.in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_out_valid", {31'd0, intf.out_valid}, 32'd0);
        base = got_out.size();
        send(1, 1, 7, 1'b1, 1'b0);
        drain();
        chk("midrst_count", got_out.size() - base, 32'd1);
        if (got_out.size() == base + 1) chk("midrst_acc_cleared", got_out[base], 32'd1);

        // Random traffic with random backpressure and idle gaps.
        for (int i = 0; i < 300; i++) begin
            send(int'($signed(16'($urandom))), int'($signed(16'($urandom))),
                 int'($signed(16'($urandom))), 1'($urandom_range(0, 1)), 1'b1);
            if ($urandom_range(0, 4) == 0) begin
                intf.in_valid = 1'b0;
                intf.out_ready = ($urandom_range(0, 1) != 0);
                @(posedge clk); #1;
            end
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
